// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_pkg
//  Description : Shared types and constants for the 64b/66b PCS TX path.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcs_pkg;

    localparam int PCS_SEQ_MAX = 32;
    localparam int PCS_HDR_W   = 2;
    localparam int PCS_BLOCK_W = 66;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } tx_seq_state_e;

endpackage : pcs_pkg
`default_nettype wire

// File: rtl/pcs_tx_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_tx_seq_ctrl_if
//  Description : Encoder/scrambler/gearbox control bundle of the TX sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pcs_tx_seq_ctrl_if #(
    parameter int SEQ_WIDTH = 6
);
    logic                 i_enable;
    logic                 i_enc_valid;
    logic                 o_enc_ready;
    logic                 o_scr_valid;
    logic [SEQ_WIDTH-1:0] o_gb_seq;
    logic                 o_gb_hdr_valid;
    logic                 o_gb_pause;
    logic                 o_active;
    logic                 o_overrun;

    // The sequencer is the slave; the surrounding datapath/controller drives it.
    modport slave (
        input  i_enable, i_enc_valid,
        output o_enc_ready, o_scr_valid, o_gb_seq, o_gb_hdr_valid,
               o_gb_pause, o_active, o_overrun
    );

    modport master (
        output i_enable, i_enc_valid,
        input  o_enc_ready, o_scr_valid, o_gb_seq, o_gb_hdr_valid,
               o_gb_pause, o_active, o_overrun
    );
endinterface : pcs_tx_seq_ctrl_if
`default_nettype wire

// File: rtl/pcs_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_seq_counter
//  Description : Gearbox seq/half counter; seq SEQ_MAX is the pause slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcs_seq_counter #(
    parameter int SEQ_MAX   = 32,
    parameter int SEQ_WIDTH = 6
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 clr,
    input  wire logic                 step,
    output logic      [SEQ_WIDTH-1:0] seq,
    output logic                      half
);
    localparam logic [SEQ_WIDTH-1:0] C_SEQ_PAUSE = SEQ_WIDTH'(SEQ_MAX);

    logic [SEQ_WIDTH-1:0] r_seq;
    logic                 r_half;

    // Stepping past the last data slot lands on SEQ_MAX, and the second
    // half of the pause slot wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_seq  <= '0;
            r_half <= 1'b0;
        end else if (step) begin
            r_half <= ~r_half;
            if (r_half) begin
                if (r_seq == C_SEQ_PAUSE) begin
                    r_seq <= '0;
                end else begin
                    r_seq <= r_seq + SEQ_WIDTH'(1);
                end
            end
        end
    end

    assign seq  = r_seq;
    assign half = r_half;

endmodule : pcs_seq_counter
`default_nettype wire

// File: rtl/pcs_tx_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_tx_seq_ctrl
//  Description : TX sequencer pacing encoder/scrambler and gearbox controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcs_tx_seq_ctrl
    import pcs_pkg::*;
#(
    parameter int SEQ_MAX   = PCS_SEQ_MAX,
    parameter int SEQ_WIDTH = 6
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset,
    pcs_tx_seq_ctrl_if.slave bus
);
    localparam logic [SEQ_WIDTH-1:0] C_SEQ_LAST_DATA = SEQ_WIDTH'(SEQ_MAX - 1);

    tx_seq_state_e        r_state;
    logic                 r_enc_ready;
    logic                 r_active;
    logic [SEQ_WIDTH-1:0] r_gb_seq;
    logic                 r_gb_hdr_valid;
    logic                 r_gb_pause;
    logic                 r_overrun;

    logic [SEQ_WIDTH-1:0] w_seq;
    logic                 w_half;
    logic                 w_clr;
    logic                 w_step;

    // Disable only takes effect at a block boundary (half==1), which also
    // covers the end of PAUSE; IDLE holds the counter cleared.
    assign w_step = (r_state != IDLE);
    assign w_clr  = (r_state == IDLE) | (w_half & ~bus.i_enable);

    pcs_seq_counter #(
        .SEQ_MAX   (SEQ_MAX),
        .SEQ_WIDTH (SEQ_WIDTH)
    ) u_seq_counter (
        .clk  (i_clk),
        .rst  (i_reset),
        .clr  (w_clr),
        .step (w_step),
        .seq  (w_seq),
        .half (w_half)
    );

    // A disable at the wrap boundary wins over entering PAUSE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_enc_ready <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_enable) begin
                        r_state     <= RUN;
                        r_enc_ready <= 1'b1;
                        r_active    <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_half) begin
                        if (!bus.i_enable) begin
                            r_state     <= IDLE;
                            r_enc_ready <= 1'b0;
                            r_active    <= 1'b0;
                        end else if (w_seq == C_SEQ_LAST_DATA) begin
                            r_state     <= PAUSE;
                            r_enc_ready <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (w_half) begin
                        if (bus.i_enable) begin
                            r_state     <= RUN;
                            r_enc_ready <= 1'b1;
                        end else begin
                            r_state     <= IDLE;
                            r_enc_ready <= 1'b0;
                            r_active    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_enc_ready <= 1'b0;
                    r_active    <= 1'b0;
                end
            endcase
        end
    end

    // Gearbox controls trail by one cycle to line up with scrambler output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gb_seq       <= '0;
            r_gb_hdr_valid <= 1'b0;
            r_gb_pause     <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_gb_seq       <= w_seq;
            r_gb_hdr_valid <= (r_state == RUN) && !w_half;
            r_gb_pause     <= (r_state == PAUSE);
            if (bus.i_enc_valid && !r_enc_ready && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.o_enc_ready    = r_enc_ready;
    assign bus.o_scr_valid    = r_enc_ready & bus.i_enc_valid;
    assign bus.o_gb_seq       = r_gb_seq;
    assign bus.o_gb_hdr_valid = r_gb_hdr_valid;
    assign bus.o_gb_pause     = r_gb_pause;
    assign bus.o_active       = r_active;
    assign bus.o_overrun      = r_overrun;

endmodule : pcs_tx_seq_ctrl
`default_nettype wire

// File: tb/tb_pcs_tx_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcs_tx_seq_ctrl
//  Description : Directed self-checking bench for the PCS TX sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_seq_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic exp_overrun;

    pcs_tx_seq_ctrl_if #(.SEQ_WIDTH(6)) bus ();

    pcs_tx_seq_ctrl #(
        .SEQ_MAX   (32),
        .SEQ_WIDTH (6)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // k = cycles since entering RUN; a period is 64 ready cycles + 2 pause cycles.
    task automatic step_run(input int k);
        int   j;
        logic exp_rdy;
        @(posedge clk);
        #1;
        exp_rdy = ((k % 66) < 64);
        bus.i_enc_valid = exp_rdy;
        #1;
        check("enc_ready", bus.o_enc_ready, exp_rdy);
        check("scr_valid", bus.o_scr_valid, exp_rdy);
        check("active", bus.o_active, 1);
        check("overrun", bus.o_overrun, exp_overrun);
        if (k == 0) begin
            check("gb_seq", bus.o_gb_seq, 0);
            check("gb_hdr", bus.o_gb_hdr_valid, 0);
            check("gb_pause", bus.o_gb_pause, 0);
        end else begin
            j = (k - 1) % 66;
            check("gb_seq", bus.o_gb_seq, (j < 64) ? (j / 2) : 32);
            check("gb_hdr", bus.o_gb_hdr_valid, (j < 64) && ((j % 2) == 0));
            check("gb_pause", bus.o_gb_pause, (j >= 64));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        exp_overrun     = 1'b0;
        rst             = 1'b1;
        bus.i_enable    = 1'b1;
        bus.i_enc_valid = 1'b0;

        // Reset held three cycles with enable high.
        repeat (3) tick();
        check("rst_ready", bus.o_enc_ready, 0);
        check("rst_scr", bus.o_scr_valid, 0);
        check("rst_gb_seq", bus.o_gb_seq, 0);
        check("rst_gb_hdr", bus.o_gb_hdr_valid, 0);
        check("rst_gb_pause", bus.o_gb_pause, 0);
        check("rst_active", bus.o_active, 0);
        check("rst_overrun", bus.o_overrun, 0);
        rst = 1'b0;

        // Three full periods plus the start of a fourth, up to seq 5 half 0.
        for (int k = 0; k <= 208; k++) step_run(k);

        // Disable in the first half of seq 5: second half still issues.
        bus.i_enable = 1'b0;
        step_run(209);
        tick();
        check("dis_ready", bus.o_enc_ready, 0);
        check("dis_active", bus.o_active, 0);
        check("dis_gb_seq", bus.o_gb_seq, 5);
        check("dis_gb_hdr", bus.o_gb_hdr_valid, 0);
        check("dis_gb_pause", bus.o_gb_pause, 0);
        bus.i_enc_valid = 1'b1;
        tick();
        check("idle_valid_ignored", bus.o_overrun, 0);
        check("idle_gb_seq", bus.o_gb_seq, 0);
        check("idle_ready", bus.o_enc_ready, 0);
        bus.i_enc_valid = 1'b0;
        bus.i_enable    = 1'b1;

        // Restart at seq 0, then offer data in the first pause cycle.
        for (int k = 0; k <= 63; k++) step_run(k);
        tick();
        bus.i_enc_valid = 1'b1;
        #1;
        check("pause_ready", bus.o_enc_ready, 0);
        check("pause_scr", bus.o_scr_valid, 0);
        check("pause_overrun_pre", bus.o_overrun, 0);
        exp_overrun = 1'b1;
        for (int k = 65; k <= 130; k++) step_run(k);

        // Reset in the second pause cycle of the next period.
        tick();
        bus.i_enc_valid = 1'b0;
        check("p2_gb_pause", bus.o_gb_pause, 1);
        check("p2_overrun", bus.o_overrun, 1);
        rst = 1'b1;
        tick();
        check("rstp_ready", bus.o_enc_ready, 0);
        check("rstp_active", bus.o_active, 0);
        check("rstp_gb_seq", bus.o_gb_seq, 0);
        check("rstp_gb_pause", bus.o_gb_pause, 0);
        check("rstp_overrun", bus.o_overrun, 0);
        exp_overrun = 1'b0;
        rst = 1'b0;

        // Disable exactly at the seq 31 second-half boundary: pause skipped.
        for (int k = 0; k <= 63; k++) step_run(k);
        bus.i_enable = 1'b0;
        tick();
        check("wrapdis_ready", bus.o_enc_ready, 0);
        check("wrapdis_active", bus.o_active, 0);
        check("wrapdis_gb_seq", bus.o_gb_seq, 31);
        check("wrapdis_gb_hdr", bus.o_gb_hdr_valid, 0);
        check("wrapdis_gb_pause", bus.o_gb_pause, 0);
        tick();
        check("wrapdis_gb_pause2", bus.o_gb_pause, 0);
        check("wrapdis_gb_seq2", bus.o_gb_seq, 0);
        check("wrapdis_ready2", bus.o_enc_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pcs_tx_seq_ctrl
`default_nettype wire

// File: doc/pcs_tx_seq_ctrl.md
Name: pcs_tx_seq_ctrl

Overview:
- TX-side sequencer for the 32-bit 64b/66b PCS path: encoder → scrambler → gearbox.
- Paces the encoder and the scrambler valid so that one 66-bit block (2-bit header plus 64 payload bits) enters as two 32-bit halves.
- Drives the gearbox sequence counter, header-valid and pause controls.
- The sequence counter runs 0..32. Seq 32 is a 2-cycle pause that absorbs the 2 header bits accumulated per block: 64 data cycles plus 2 pause cycles, for 66 cycles per period.

Parameters:
- SEQ_MAX, 32, last sequence value; seq SEQ_MAX is the pause slot.
- SEQ_WIDTH, 6, width of the sequence counter; must be ≥ clog2(SEQ_MAX+1).

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  level; 1 = run the TX datapath.
- i_enc_valid  in  1  encoder presents a 32-bit half-block this cycle.
- o_enc_ready  out  1  encoder may transfer this cycle.
- o_scr_valid  out  1  drives scrambler i_data_valid; equals o_enc_ready & i_enc_valid (combinational).
- o_gb_seq  out  SEQ_WIDTH  gearbox sequence value, aligned to scrambler output.
- o_gb_hdr_valid  out  1  aligned scrambler word is the first half of a block (header attached).
- o_gb_pause  out  1  gearbox pause slot, aligned to scrambler output.
- o_active  out  1  state ≠ IDLE.
- o_overrun  out  1  sticky; set when the encoder offers data while the sequencer is not ready.

Behaviour:
- Reset: one synchronous, active-high reset. Every output and register clears to 0: state=IDLE, seq=0, half=0, o_overrun=0. Reset has priority over all other events, including reset mid-PAUSE or mid-block; no partial block completes.
- States: IDLE, RUN, PAUSE. Encoding is a 2-bit enum. o_enc_ready = (state==RUN) and is decoded from registered state only.
- IDLE:
  - o_enc_ready=0.
  - If i_enable=1 at edge t, state=RUN at t+1 with seq=0 and half=0, so o_enc_ready=1 from t+1.
- RUN, every cycle:
  - half toggles.
  - On the cycle with half=1, seq increments at the edge.
  - If seq==SEQ_MAX-1 and half==1, the next state is PAUSE with seq=SEQ_MAX and half=0.
- PAUSE:
  - Lasts exactly 2 cycles: half goes 0 then 1. o_enc_ready=0.
  - Then seq=0, half=0, state=RUN (or IDLE, see disable rule).
- Period: 2×SEQ_MAX ready cycles plus 2 pause cycles. Default: 64 + 2 = 66.
- Progress: the counters advance regardless of i_enc_valid. The encoder must supply data on every ready cycle. A missed ready cycle is not an error, but the scrambler does not advance.
- Disable: sampled only at block boundaries, i.e. at the end of a half=1 cycle in RUN or at the end of PAUSE.
  - If i_enable=0 there, next state is IDLE with seq=0 and half=0.
  - A block in flight (half=0 already issued) always completes its second half.
  - A started PAUSE always completes.
- Gearbox alignment: the scrambler has 1-cycle latency. o_gb_seq, o_gb_hdr_valid and o_gb_pause are registered copies of seq, (RUN & half==0) and (state==PAUSE), delayed by one cycle; all reset to 0.
- Overrun: o_overrun sets when i_enc_valid=1 and o_enc_ready=0 while state≠IDLE. It is never cleared except by reset. i_enc_valid in IDLE is ignored.
- Simultaneous events: the wrap to PAUSE and a disable at the same boundary resolve to IDLE, not PAUSE; the seq=SEQ_MAX pause is skipped.

Decomposition:
- Package pcs_pkg holds:
  - typedef tx_seq_state_e {IDLE, RUN, PAUSE};
  - localparams PCS_SEQ_MAX=32, PCS_HDR_W=2, PCS_BLOCK_W=66.
- One sub-module is natural: pcs_seq_counter (seq/half counter with wrap and clear inputs). The FSM and alignment registers stay in the top.

Test Plan:
1. Reset held 3 cycles with i_enable=1 → all outputs 0; o_enc_ready rises 1 cycle after reset is released.
2. i_enable=1 and i_enc_valid=1 continuously → o_enc_ready pattern is 64 ones then 2 zeros, repeating over 3 periods. o_gb_seq follows 0,0,1,1,…,31,31,32,32, 1 cycle after the ready pattern; o_gb_hdr_valid is 1 on even data cycles; o_gb_pause is 1 only for seq 32.
3. Deassert i_enable in the half=0 cycle of seq 5 → one more ready cycle (half=1), then IDLE; o_active falls 1 cycle later; re-enabling restarts at seq 0.
4. i_enc_valid=1 during a PAUSE cycle → o_scr_valid=0 and o_overrun=1, held until reset; the counters are unaffected.
5. Assert i_reset during the second PAUSE cycle → next cycle state=IDLE, seq=0, o_gb_pause=0.
6. i_enable drops exactly at the seq 31 half=1 boundary → next state IDLE; no pause is issued and o_gb_pause stays 0.
